// File: rtl/pad_pattern_pkg.sv
// Shared types and constants for the pad pattern engine.
package pad_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'b00,
    MODE_PLAY    = 2'b01,
    MODE_CAPTURE = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_PLAY,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  localparam logic [15:0] MISR_POLY   = 16'h1021;
  localparam logic [15:0] MISR_SEED   = 16'hFFFF;
  localparam int          DATA_LANE_W = 8;

  // One MISR clock: shift with polynomial feedback, then fold in the byte.
  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [7:0] din);
    logic [15:0] shifted;
    shifted = {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000);
    return shifted ^ {8'h00, din};
  endfunction

endpackage

// File: rtl/gf180mcu_fd_ip_sram__sram512x8m8wm1.sv
// Behavioural stand-in for the gf180mcu 512x8 SRAM macro: active-low CEN/GWEN/WEN, registered Q.
module gf180mcu_fd_ip_sram__sram512x8m8wm1 (
`ifdef USE_POWER_PINS
  inout  wire        VDD,
  inout  wire        VSS,
`endif
  input  logic       CLK,
  input  logic       CEN,
  input  logic       GWEN,
  input  logic [7:0] WEN,
  input  logic [8:0] A,
  input  logic [7:0] D,
  output logic [7:0] Q
);

  logic [7:0] mem [512];

  // Q only updates on reads; a write leaves the previous read data in place.
  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        for (int i = 0; i < 8; i++)
          if (!WEN[i]) mem[A][i] <= D[i];
      end else begin
        Q <= mem[A];
      end
    end
  end

endmodule

// File: rtl/pad_pattern_misr.sv
// 16-bit MISR compacting captured pad bytes; used when PAD_PATTERN_MISR_EN is defined.
module pad_pattern_misr
  import pad_pattern_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [15:0] sig
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      sig <= MISR_SEED;
    else if (en)
      sig <= misr_step(sig, din);
  end

endmodule

// File: rtl/pad_pattern_engine.sv
// Pad pattern engine: free counter, SRAM playback and pad capture on the bidir ring.
// Define PAD_PATTERN_MISR_EN to add the capture signature MISR.
//
//   state      | meaning
//   ST_IDLE    | waiting for start, pads hold last value
//   ST_COUNT   | pads driven with free-running counter
//   ST_PLAY    | SRAM read back onto pads, upper lane shows wrap count
//   ST_CAPTURE | low byte sampled into SRAM, upper lane shows address
//   ST_DONE    | capture finished, pads hold last value
module pad_pattern_engine
  import pad_pattern_pkg::*;
#(
  parameter int NUM_BIDIR_PADS = 40,
  parameter int ADDR_W         = 9
) (
`ifdef USE_POWER_PINS
  inout  wire                      vdd,
  inout  wire                      vss,
`endif
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic [1:0]                mode,
  input  logic [NUM_BIDIR_PADS-1:0] bidir_in,
  output logic [NUM_BIDIR_PADS-1:0] bidir_out,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               signature
);

  localparam int N = NUM_BIDIR_PADS;

  state_e            state, state_nxt;
  logic              accept;
  logic [N-1:0]      count, wrap_cnt, hold_q;
  logic [ADDR_W-1:0] addr;
  logic              valid;
  logic              sram_cen, sram_gwen;
  logic [7:0]        sram_wen, sram_q;
  logic              bidir_in_unused;

  assign accept = start && (state == ST_IDLE || state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = 8'hFF;
    bidir_oe  = '1;
    bidir_out = hold_q;
    case (state)
      ST_IDLE, ST_DONE: begin
        done = (state == ST_DONE);
        if (start) begin
          case (mode_e'(mode))
            MODE_PLAY:    state_nxt = ST_PLAY;
            MODE_CAPTURE: state_nxt = ST_CAPTURE;
            default:      state_nxt = ST_COUNT;
          endcase
        end
      end
      ST_COUNT: begin
        busy      = 1'b1;
        bidir_out = count;
        if (stop) state_nxt = ST_IDLE;
      end
      ST_PLAY: begin
        busy      = 1'b1;
        sram_cen  = 1'b0;
        bidir_out = (wrap_cnt << DATA_LANE_W) | N'(valid ? sram_q : 8'h00);
        if (stop) state_nxt = ST_IDLE;
      end
      ST_CAPTURE: begin
        busy      = 1'b1;
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = 8'h00;
        bidir_oe  = {N{1'b1}} << DATA_LANE_W;
        bidir_out = N'(addr) << DATA_LANE_W;
        if (stop)           state_nxt = ST_IDLE;
        else if (addr == '1) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bidir_ie = ~bidir_oe;

  // hold_q tracks whatever the pads show so IDLE/DONE can freeze it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      wrap_cnt <= '0;
      hold_q   <= '0;
      addr     <= '0;
      valid    <= 1'b0;
    end else begin
      hold_q <= bidir_out;
      if (accept) begin
        count    <= '0;
        wrap_cnt <= '0;
        addr     <= '0;
        valid    <= 1'b0;
      end else begin
        case (state)
          ST_COUNT: count <= count + 1'b1;
          ST_PLAY: begin
            addr  <= addr + 1'b1;
            valid <= 1'b1;
            if (addr == '1) wrap_cnt <= wrap_cnt + 1'b1;
          end
          ST_CAPTURE: addr <= addr + 1'b1;
          default: ;
        endcase
      end
    end
  end

  gf180mcu_fd_ip_sram__sram512x8m8wm1 u_sram (
`ifdef USE_POWER_PINS
    .VDD  (vdd),
    .VSS  (vss),
`endif
    .CLK  (clk),
    .CEN  (sram_cen),
    .GWEN (sram_gwen),
    .WEN  (sram_wen),
    .A    (9'(addr)),
    .D    (bidir_in[7:0]),
    .Q    (sram_q)
  );

`ifdef PAD_PATTERN_MISR_EN
  pad_pattern_misr u_misr (
    .clk (clk),
    .rst (rst),
    .clr (accept && (mode_e'(mode) == MODE_CAPTURE)),
    .en  (state == ST_CAPTURE),
    .din (bidir_in[7:0]),
    .sig (signature)
  );
`else
  assign signature = 16'h0000;
`endif

  assign bidir_in_unused = ^(bidir_in >> DATA_LANE_W);

endmodule
